// File: rtl/spi_tx_frame_feeder.sv
// Upstream feeder for spi_master_v2. It buffers host TX bytes in a show-ahead FIFO
// and releases a frame to the master only once every byte of that frame is buffered.
module spi_tx_frame_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic          cmd_valid,
    input  logic [3:0]    cmd_len,
    input  logic [1:0]    cmd_cs,
    output logic          cmd_ready,
    output logic          spi_start,
    output logic [7:0]    spi_data_in,
    output logic [3:0]    spi_data_len,
    output logic [1:0]    spi_cs_sel,
    input  logic          spi_busy,
    input  logic          spi_done,
    input  logic          spi_byte_load,
    output logic          frame_done,
    output logic          ovf_err,
    output logic          unf_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        START,
        RUN
    } state_t;

    state_t        state, state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level_eff;
    logic          push, pop;

    logic [3:0]    remaining, remaining_nxt;
    logic          latch_cmd;
    logic          frame_done_nxt;
    logic          unf_set;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (level == '0);
    assign push      = wr_en && !full;
    // A byte written this cycle already counts towards the frame being waited on.
    assign level_eff = level + (AW+1)'(push);

    // NOTE: the storage array has no reset; pointers and level alone decide which
    // entries are valid, so clearing the array would only cost a reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments, so every register here sees pre-edge values
    // regardless of the order the statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_en && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // Show-ahead head byte, only visible to the master while a frame is live.
    assign spi_data_in = (state == START || state == RUN) ? mem[rd_ptr] : 8'h00;

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            remaining    <= '0;
            spi_data_len <= '0;
            spi_cs_sel   <= '0;
            frame_done   <= 1'b0;
            unf_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            frame_done <= frame_done_nxt;
            if (latch_cmd) begin
                spi_data_len <= cmd_len;
                spi_cs_sel   <= cmd_cs;
            end
            if (unf_set) begin
                unf_err <= 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        pop            = 1'b0;
        latch_cmd      = 1'b0;
        frame_done_nxt = 1'b0;
        unf_set        = 1'b0;
        cmd_ready      = 1'b0;
        spi_start      = 1'b0;

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    latch_cmd = 1'b1;
                    if (cmd_len == 4'd0) begin
                        frame_done_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end
            end

            WAIT_DATA: begin
                if (level_eff >= (AW+1)'(spi_data_len) && !spi_busy) begin
                    state_nxt = START;
                end
            end

            START: begin
                spi_start     = 1'b1;
                pop           = !empty;
                remaining_nxt = spi_data_len - 4'd1;
                state_nxt     = RUN;
            end

            RUN: begin
                // A load coinciding with done is still honoured before leaving.
                if (spi_byte_load) begin
                    if (remaining != 4'd0) begin
                        pop           = !empty;
                        remaining_nxt = remaining - 4'd1;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
                if (spi_done) begin
                    frame_done_nxt = 1'b1;
                    state_nxt      = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
